// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with a shared period counter and double-buffered
// period/mode/compare configuration committed only at a period boundary.
module pwm_gen_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_en,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                period_we,
    input  logic [CHANNELS-1:0] cfg_we,
    input  logic [1:0]          cfg_mode,
    input  logic [WIDTH-1:0]    cfg_cmp1,
    input  logic [WIDTH-1:0]    cfg_cmp2,
    input  logic                update_req,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [WIDTH-1:0]    count,
    output logic                period_end,
    output logic                update_pending
);

    typedef enum logic [1:0] {
        MODE_LEFT  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_RANGE = 2'b10,
        MODE_PARK  = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    staged_period;
    logic [WIDTH-1:0]    active_period;
    mode_t               staged_mode [CHANNELS];
    mode_t               active_mode [CHANNELS];
    logic [WIDTH-1:0]    staged_cmp1 [CHANNELS];
    logic [WIDTH-1:0]    staged_cmp2 [CHANNELS];
    logic [WIDTH-1:0]    active_cmp1 [CHANNELS];
    logic [WIDTH-1:0]    active_cmp2 [CHANNELS];

    logic [WIDTH-1:0]    p_eff;
    logic [WIDTH-1:0]    last_count;
    logic                wrap;
    logic                commit;
    logic [CHANNELS-1:0] hit;

    assign p_eff      = (active_period == '0) ? ONE : active_period;
    assign last_count = p_eff - ONE;
    // >= rather than == so a shrunken period still wraps from a larger count
    assign wrap       = pwm_en && (count >= last_count);
    // A request arriving on the wrap edge is honoured by that same wrap
    assign commit     = pwm_en ? (wrap && (update_pending || update_req))
                               : update_pending;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            unique case (active_mode[i])
                MODE_LEFT:  hit[i] = (count < active_cmp1[i]);
                MODE_RIGHT: hit[i] = (count >= active_cmp1[i]);
                MODE_RANGE: hit[i] = (count >= active_cmp1[i]) && (count < active_cmp2[i]);
                default:    hit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count          <= '0;
            period_end     <= 1'b0;
            pwm_out        <= '0;
            update_pending <= 1'b0;
        end else begin
            if (!pwm_en || wrap) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
            period_end     <= wrap;
            pwm_out        <= pwm_en ? hit : '0;
            update_pending <= commit ? 1'b0 : (update_pending || update_req);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_period <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                staged_mode[i] <= MODE_LEFT;
                staged_cmp1[i] <= '0;
                staged_cmp2[i] <= '0;
            end
        end else begin
            if (period_we) begin
                staged_period <= cfg_period;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (cfg_we[i]) begin
                    staged_mode[i] <= mode_t'(cfg_mode);
                    staged_cmp1[i] <= cfg_cmp1;
                    staged_cmp2[i] <= cfg_cmp2;
                end
            end
        end
    end

    // Commit samples pre-edge staged values, so a coincident write waits for the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_period <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                active_mode[i] <= MODE_LEFT;
                active_cmp1[i] <= '0;
                active_cmp2[i] <= '0;
            end
        end else if (commit) begin
            active_period <= staged_period;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                active_mode[i] <= staged_mode[i];
                active_cmp1[i] <= staged_cmp1[i];
                active_cmp2[i] <= staged_cmp2[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench for pwm_gen_multi: staging, commit timing, period changes,
// coincident events and asynchronous reset, checked with immediate assertions.
module tb_pwm_gen_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_en;
    logic [15:0] cfg_period;
    logic        period_we;
    logic [3:0]  cfg_we;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_cmp1;
    logic [15:0] cfg_cmp2;
    logic        update_req;
    logic [3:0]  pwm_out;
    logic [15:0] count;
    logic        period_end;
    logic        update_pending;

    int    errors = 0;
    int    checks = 0;
    string phase  = "reset";

    always #5 clk = ~clk;

    pwm_gen_multi #(.WIDTH(16), .CHANNELS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwm_en         (pwm_en),
        .cfg_period     (cfg_period),
        .period_we      (period_we),
        .cfg_we         (cfg_we),
        .cfg_mode       (cfg_mode),
        .cfg_cmp1       (cfg_cmp1),
        .cfg_cmp2       (cfg_cmp2),
        .update_req     (update_req),
        .pwm_out        (pwm_out),
        .count          (count),
        .period_end     (period_end),
        .update_pending (update_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int ec, input logic [3:0] eo, input logic ep, input logic epd);
        tick;
        chk("count", {16'd0, count}, ec);
        chk("pwm_out", {28'd0, pwm_out}, {28'd0, eo});
        chk("period_end", {31'd0, period_end}, {31'd0, ep});
        chk("update_pending", {31'd0, update_pending}, {31'd0, epd});
    endtask

    // ch0 left-aligned (cmp0), ch1 right-aligned at 7, ch2 range 2..4 when rng, ch3 parked
    function automatic logic [3:0] duty(input int c, input int cmp0, input bit rng);
        logic [3:0] r;
        r[0] = (c < cmp0);
        r[1] = (c >= 7);
        r[2] = rng && (c >= 2) && (c < 5);
        r[3] = 1'b0;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pwm_en = 1'b0; cfg_period = '0; period_we = 1'b0;
        cfg_we = '0; cfg_mode = '0; cfg_cmp1 = '0; cfg_cmp2 = '0; update_req = 1'b0;
        #12;
        chk("count", {16'd0, count}, 0);
        chk("pwm_out", {28'd0, pwm_out}, 0);
        chk("period_end", {31'd0, period_end}, 0);
        chk("update_pending", {31'd0, update_pending}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "stage";
        cfg_period = 16'd10; period_we = 1'b1;
        step(0, 4'b0000, 0, 0);
        period_we = 1'b0;
        cfg_we = 4'b0001; cfg_mode = 2'b00; cfg_cmp1 = 16'd3; cfg_cmp2 = 16'd0;
        step(0, 4'b0000, 0, 0);
        cfg_we = 4'b0010; cfg_mode = 2'b01; cfg_cmp1 = 16'd7; cfg_cmp2 = 16'd0;
        step(0, 4'b0000, 0, 0);
        cfg_we = 4'b0100; cfg_mode = 2'b10; cfg_cmp1 = 16'd2; cfg_cmp2 = 16'd5;
        step(0, 4'b0000, 0, 0);
        cfg_we = 4'b1000; cfg_mode = 2'b11; cfg_cmp1 = 16'd5; cfg_cmp2 = 16'd9;
        step(0, 4'b0000, 0, 0);
        cfg_we = 4'b0000;
        update_req = 1'b1;
        step(0, 4'b0000, 0, 1);
        update_req = 1'b0;
        step(0, 4'b0000, 0, 0);

        phase = "run_p10";
        pwm_en = 1'b1;
        for (int k = 1; k <= 24; k++) step(k % 10, duty((k - 1) % 10, 3, 1), (k % 10) == 0, 0);

        phase = "mid_update";
        cfg_we = 4'b0001; cfg_mode = 2'b00; cfg_cmp1 = 16'd8; cfg_cmp2 = 16'd0; update_req = 1'b1;
        step(5, duty(4, 3, 1), 0, 1);
        cfg_we = 4'b0000; update_req = 1'b0;
        for (int k = 26; k <= 29; k++) step(k % 10, duty((k - 1) % 10, 3, 1), 0, 1);
        step(0, duty(9, 3, 1), 1, 0);
        for (int k = 31; k <= 46; k++) step(k % 10, duty((k - 1) % 10, 8, 1), (k % 10) == 0, 0);

        phase = "shrink";
        cfg_period = 16'd4; period_we = 1'b1; update_req = 1'b1;
        step(7, duty(6, 8, 1), 0, 1);
        period_we = 1'b0; update_req = 1'b0;
        step(8, duty(7, 8, 1), 0, 1);
        step(9, duty(8, 8, 1), 0, 1);
        step(0, duty(9, 8, 1), 1, 0);
        for (int j = 1; j <= 11; j++) step(j % 4, duty((j - 1) % 4, 8, 1), (j % 4) == 0, 0);

        phase = "wrap_edge_write";
        cfg_we = 4'b0001; cfg_mode = 2'b00; cfg_cmp1 = 16'd2; cfg_cmp2 = 16'd0; update_req = 1'b1;
        step(0, duty(3, 8, 1), 1, 0);
        cfg_we = 4'b0000; update_req = 1'b0;
        for (int j = 1; j <= 4; j++) step(j % 4, duty((j - 1) % 4, 8, 1), (j % 4) == 0, 0);

        phase = "second_commit";
        update_req = 1'b1;
        step(1, duty(0, 8, 1), 0, 1);
        step(2, duty(1, 8, 1), 0, 1);
        update_req = 1'b0;
        step(3, duty(2, 8, 1), 0, 1);
        step(0, duty(3, 8, 1), 1, 0);
        for (int j = 1; j <= 4; j++) step(j % 4, duty((j - 1) % 4, 2, 1), (j % 4) == 0, 0);

        phase = "range_equal";
        cfg_we = 4'b0100; cfg_mode = 2'b10; cfg_cmp1 = 16'd5; cfg_cmp2 = 16'd5; update_req = 1'b1;
        step(1, duty(0, 2, 1), 0, 1);
        cfg_we = 4'b0000; update_req = 1'b0;
        step(2, duty(1, 2, 1), 0, 1);
        step(3, duty(2, 2, 1), 0, 1);
        step(0, duty(3, 2, 1), 1, 0);
        for (int j = 1; j <= 4; j++) step(j % 4, duty((j - 1) % 4, 2, 0), (j % 4) == 0, 0);

        phase = "period_zero";
        cfg_period = 16'd0; period_we = 1'b1; update_req = 1'b1;
        step(1, duty(0, 2, 0), 0, 1);
        period_we = 1'b0; update_req = 1'b0;
        step(2, duty(1, 2, 0), 0, 1);
        step(3, duty(2, 2, 0), 0, 1);
        step(0, duty(3, 2, 0), 1, 0);
        for (int j = 1; j <= 4; j++) step(0, duty(0, 2, 0), 1, 0);

        phase = "disable";
        pwm_en = 1'b0;
        step(0, 4'b0000, 0, 0);

        phase = "async_reset";
        cfg_period = 16'd10; period_we = 1'b1; update_req = 1'b1;
        step(0, 4'b0000, 0, 1);
        period_we = 1'b0; update_req = 1'b0;
        step(0, 4'b0000, 0, 0);
        pwm_en = 1'b1;
        step(1, duty(0, 2, 0), 0, 0);
        update_req = 1'b1;
        step(2, duty(1, 2, 0), 0, 1);
        update_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("count", {16'd0, count}, 0);
        chk("pwm_out", {28'd0, pwm_out}, 0);
        chk("period_end", {31'd0, period_end}, 0);
        chk("update_pending", {31'd0, update_pending}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "after_reset";
        step(0, 4'b0000, 1, 0);
        update_req = 1'b1;
        step(0, 4'b0000, 1, 0);
        update_req = 1'b0;
        step(0, 4'b0000, 1, 0);
        step(0, 4'b0000, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
